// File: rtl/nand_seq_pkg.sv
// nand_seq_pkg: state encoding, settle default and reference NAND response shared by the sequencer
package nand_seq_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;
  localparam int SETTLE_CYCLES_DEF = 2;
  function automatic logic nand_exp(input logic a, input logic b);
    return ~(a & b);
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: down-counter timing how long each vector is held
// Ports: clk, rst (sync, active-high), load_i loads val_i into the counter,
//        count_o is the current count, expired_o flags the final held cycle (count == 1).
module settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] val_i,
  output logic [3:0] count_o,
  output logic       expired_o
);
  logic [3:0] count_q, count_d;
  assign count_d = load_i ? val_i : (count_q != 4'd0) ? count_q - 4'd1 : count_q;
  always_ff @(posedge clk) begin
    count_q <= rst ? 4'd0 : count_d;
  end
  assign count_o = count_q;
  assign expired_o = (count_q == 4'd1);
endmodule

// File: rtl/nand_test_sequencer.sv
// nand_test_sequencer: exhaustive 4-vector self-test of an external two-input NAND gate
// Ports: clk, rst (sync, active-high), start (run request, honoured only in IDLE),
//        dut_y (gate response), dut_a/dut_b (gate stimulus), busy (SETTLE..CHECK),
//        done (one-cycle result pulse), pass (last run clean), err_count (mismatches 0..4),
//        fail_vec (bit k set when vector k mismatched).
module nand_test_sequencer
  import nand_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);
  logic [1:0] st_q, st_d, k_q, k_d;
  logic [2:0] err_q, err_d;
  logic [3:0] fail_q, fail_d, cnt;
  logic       pass_q, pass_d, load, expired, mis;
  settle_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .val_i     (4'(SETTLE_CYCLES)),
    .count_o   (cnt),
    .expired_o (expired)
  );
  assign mis = (st_q == ST_CHECK) && (dut_y != nand_exp(k_q[1], k_q[0]));
  always_comb begin
    st_d   = st_q;
    k_d    = k_q;
    err_d  = err_q;
    fail_d = fail_q;
    pass_d = pass_q;
    load   = 1'b0;
    case (st_q)
      ST_IDLE: if (start) begin
        st_d   = ST_SETTLE;
        k_d    = 2'd0;
        err_d  = 3'd0;
        fail_d = 4'd0;
        pass_d = 1'b0;
        load   = 1'b1;
      end
      ST_SETTLE: st_d = expired ? ST_CHECK : ST_SETTLE;
      ST_CHECK: begin
        err_d  = (mis && err_q != 3'd4) ? err_q + 3'd1 : err_q;
        fail_d = mis ? fail_q | (4'b0001 << k_q) : fail_q;
        st_d   = (k_q == 2'd3) ? ST_DONE : ST_SETTLE;
        k_d    = (k_q == 2'd3) ? k_q : k_q + 2'd1;
        load   = (k_q != 2'd3);
        pass_d = (k_q == 2'd3) ? (err_d == 3'd0) : pass_q;
      end
      default: st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ST_IDLE;
      k_q    <= 2'd0;
      err_q  <= 3'd0;
      fail_q <= 4'd0;
      pass_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      k_q    <= k_d;
      err_q  <= err_d;
      fail_q <= fail_d;
      pass_q <= pass_d;
    end
  end
  // The timer is nonzero exactly while a vector is settling, so together with CHECK it spans the run.
  assign busy      = (cnt != 4'd0) || (st_q == ST_CHECK);
  // Stimulus follows the vector index while busy and is forced low in IDLE/DONE.
  assign dut_a     = busy & k_q[1];
  assign dut_b     = busy & k_q[0];
  assign done      = (st_q == ST_DONE);
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;
endmodule

// File: doc/nand_test_sequencer.md
NAND_TEST_SEQUENCER -- requirements
Module: nand_test_sequencer

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles each vector is held before Y is sampled (legal range 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one full exhaustive test run; sampled only in IDLE.
REQ-005 dut_y  input  1  output Y of the NAND gate under test.
REQ-006 dut_a  output  1  drives input A of the gate under test.
REQ-007 dut_b  output  1  drives input B of the gate under test.
REQ-008 busy  output  1  high from the first SETTLE cycle through the last CHECK cycle.
REQ-009 done  output  1  one-cycle pulse when results become valid.
REQ-010 pass  output  1  high when the last completed run had zero mismatches.
REQ-011 err_count  output  3  number of mismatching vectors in the last run (0..4).
REQ-012 fail_vec  output  4  bit k set when vector k mismatched.

Function
REQ-013 The block SHALL apply the vectors in order k = 0,1,2,3 with dut_a = k[1] and dut_b = k[0] (AB = 00, 01, 10, 11).
REQ-014 The expected response for vector k SHALL be ~(dut_a & dut_b), i.e. 1,1,1,0.
REQ-015 The FSM SHALL have states IDLE, SETTLE, CHECK and DONE, and no others.
REQ-016 IDLE -> SETTLE occurs when start=1; vector index = 0, fail_vec = 0, err_count = 0 and pass = 0 are loaded on the same edge.
REQ-017 In SETTLE, the vector SHALL be held for exactly SETTLE_CYCLES cycles, then the FSM SHALL enter CHECK.
REQ-018 In CHECK (one cycle), dut_y SHALL be compared to the expected value; any mismatch sets fail_vec[k] and increments err_count on the next edge.
REQ-019 CHECK with k<3 SHALL go to SETTLE with k+1; CHECK with k=3 SHALL go to DONE.
REQ-020 DONE (one cycle) SHALL assert done=1, drive pass = (final err_count==0), then return to IDLE.
REQ-021 Timing: with start sampled at edge 0, the CHECK of vector k SHALL occur at cycle (k+1)*(SETTLE_CYCLES+1), and done SHALL occur at cycle 4*(SETTLE_CYCLES+1)+1.
REQ-022 dut_a and dut_b SHALL change only on the transition into SETTLE, and SHALL be 0 in IDLE and DONE.
REQ-023 start SHALL be ignored in SETTLE, CHECK and DONE; no queuing.
REQ-024 pass, err_count and fail_vec SHALL hold their values from the end of a run until the next accepted start or reset.
REQ-025 The err_count increment SHALL saturate at 4; it cannot overflow its 3-bit width.

Reset
REQ-026 While rst=1, the FSM SHALL be in IDLE with vector index 0, settle counter 0, and all outputs 0 (dut_a, dut_b, busy, done, pass, err_count, fail_vec).
REQ-027 Reset asserted mid-run SHALL abort the run on the next edge; no done pulse SHALL be produced, and results SHALL be cleared.
REQ-028 rst SHALL have priority over start when both are high.

Structure
REQ-029 The shared package nand_seq_pkg SHALL hold:
- the state encoding (IDLE, SETTLE, CHECK, DONE);
- the SETTLE_CYCLES default;
- the expected-NAND function.
REQ-030 The settle down-counter SHALL be a separate sub-module, settle_timer, with ports load, count value and expiry flag.
REQ-031 The bench SHALL instantiate the existing two-input NAND gate as the device under test, connected to dut_a/dut_b/dut_y.

Verification
REQ-032 Good NAND, SETTLE_CYCLES=2, start pulse at edge 0 -> CHECKs at cycles 3, 6, 9, 12; done=1 at cycle 13; pass=1, err_count=0, fail_vec=0000.
REQ-033 dut_y tied to 1 -> err_count=1, fail_vec=1000, pass=0.
REQ-034 dut_y driven as A&B (AND gate) -> err_count=4, fail_vec=1111, pass=0.
REQ-035 rst pulsed at cycle 5 -> next cycle in IDLE with all outputs 0 and no done; a subsequent start gives a full correct run (same results as REQ-032).
REQ-036 start held high continuously -> exactly one run per IDLE visit; with SETTLE_CYCLES=2, done pulses at cycles 13, 27, 41.
REQ-037 SETTLE_CYCLES=1 with a good NAND -> done at cycle 9; dut_a/dut_b sequence 00,01,10,11, each held 2 cycles.
